// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter sharing one AHB-Lite master port between NB_MASTERS requesters,
// with data-phase ownership tracking and a per-master buffer for handover overlap.
module ahb_master_arbiter #(
  parameter int unsigned NB_MASTERS     = 4,
  parameter int unsigned AHB_DATA_WIDTH = 32,
  parameter int unsigned AHB_ADDR_WIDTH = 32,
  localparam int unsigned MW            = $clog2(NB_MASTERS)
) (
  input  logic                                          hclk,
  input  logic                                          hreset,
  input  logic [NB_MASTERS-1:0][AHB_ADDR_WIDTH-1:0]     m_haddr_i,
  input  logic [NB_MASTERS-1:0][AHB_DATA_WIDTH-1:0]     m_hwdata_i,
  input  logic [NB_MASTERS-1:0][1:0]                    m_htrans_i,
  input  logic [NB_MASTERS-1:0][2:0]                    m_hsize_i,
  input  logic [NB_MASTERS-1:0][2:0]                    m_hburst_i,
  input  logic [NB_MASTERS-1:0][3:0]                    m_hprot_i,
  input  logic [NB_MASTERS-1:0]                         m_hwrite_i,
  input  logic [NB_MASTERS-1:0]                         m_hmastlock_i,
  output logic [NB_MASTERS-1:0]                         m_hready_o,
  output logic [NB_MASTERS-1:0]                         m_hresp_o,
  output logic [NB_MASTERS-1:0][AHB_DATA_WIDTH-1:0]     m_hrdata_o,
  output logic [AHB_ADDR_WIDTH-1:0]                     s_haddr_o,
  output logic [1:0]                                    s_htrans_o,
  output logic [2:0]                                    s_hsize_o,
  output logic [2:0]                                    s_hburst_o,
  output logic [3:0]                                    s_hprot_o,
  output logic                                          s_hwrite_o,
  output logic                                          s_hmastlock_o,
  output logic                                          s_hsel_o,
  output logic [AHB_DATA_WIDTH-1:0]                     s_hwdata_o,
  output logic                                          s_hready_o,
  input  logic                                          s_hreadyout_i,
  input  logic                                          s_hresp_i,
  input  logic [AHB_DATA_WIDTH-1:0]                     s_hrdata_i,
  output logic [MW-1:0]                                 hmaster_o
);

  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;
  localparam logic [2:0] HB_SINGLE = 3'b000;

  logic [MW-1:0]                             gnt_q, gnt_d, rr_q, rr_d, down_q, down_d;
  logic [MW-1:0]                             winner, scan;
  logic                                      dvld_q, dvld_d, hold, found;
  logic [NB_MASTERS-1:0]                     pend_q, pend_d, presp_q, presp_d;
  logic [NB_MASTERS-1:0][AHB_DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic [NB_MASTERS-1:0]                     req, is_gnt, is_down;
  logic [1:0]                                gtrans;

  // Address-phase mux follows the grant; write data follows the data-phase owner.
  assign s_haddr_o     = m_haddr_i[gnt_q];
  assign s_htrans_o    = m_htrans_i[gnt_q];
  assign s_hsize_o     = m_hsize_i[gnt_q];
  assign s_hburst_o    = m_hburst_i[gnt_q];
  assign s_hprot_o     = m_hprot_i[gnt_q];
  assign s_hwrite_o    = m_hwrite_i[gnt_q];
  assign s_hmastlock_o = m_hmastlock_i[gnt_q];
  assign s_hsel_o      = 1'b1;
  assign s_hwdata_o    = m_hwdata_i[down_q];
  assign s_hready_o    = s_hreadyout_i;
  assign hmaster_o     = gnt_q;

  always_comb begin
    req     = '0;
    is_gnt  = '0;
    is_down = '0;
    for (int unsigned i = 0; i < NB_MASTERS; i++) begin
      req[i]     = m_htrans_i[i][1];
      is_gnt[i]  = (gnt_q == MW'(i));
      is_down[i] = dvld_q && (down_q == MW'(i));
    end
  end

  // Grant is held through bursts and locked sequences of the current owner.
  always_comb begin
    gtrans = m_htrans_i[gnt_q];
    hold   = (gtrans == HT_BUSY) || (gtrans == HT_SEQ) ||
             ((gtrans == HT_NONSEQ) && (m_hburst_i[gnt_q] != HB_SINGLE)) ||
             m_hmastlock_i[gnt_q];
  end

  // Round-robin scan starting just after the last winner.
  always_comb begin
    winner = gnt_q;
    found  = 1'b0;
    scan   = '0;
    for (int unsigned k = 1; k <= NB_MASTERS; k++) begin
      scan = MW'((32'(rr_q) + k) % NB_MASTERS);
      if (!found && req[scan]) begin
        found  = 1'b1;
        winner = scan;
      end
    end
  end

  always_comb begin
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    dvld_d     = dvld_q;
    down_d     = down_q;
    pend_d     = pend_q;
    pdata_d    = pdata_q;
    presp_d    = presp_q;
    m_hready_o = '1;
    m_hresp_o  = '0;
    m_hrdata_o = {NB_MASTERS{s_hrdata_i}};

    if (s_hreadyout_i) begin
      if (!hold && found) begin
        gnt_d = winner;
        rr_d  = winner;
      end
      dvld_d = req[gnt_q];
      down_d = gnt_q;
    end

    // A data-phase owner that lost the grant but already queued its next address
    // gets its completion buffered and replayed when it is granted again.
    for (int unsigned i = 0; i < NB_MASTERS; i++) begin
      if (pend_q[i] && is_gnt[i]) begin
        m_hready_o[i] = s_hreadyout_i;
        m_hresp_o[i]  = presp_q[i];
        m_hrdata_o[i] = pdata_q[i];
        if (s_hreadyout_i) pend_d[i] = 1'b0;
      end else if (pend_q[i]) begin
        m_hready_o[i] = 1'b0;
        m_hresp_o[i]  = presp_q[i];
        m_hrdata_o[i] = pdata_q[i];
      end else if (is_down[i] && !is_gnt[i] && req[i]) begin
        m_hready_o[i] = 1'b0;
        if (s_hreadyout_i) begin
          pend_d[i]  = 1'b1;
          pdata_d[i] = s_hrdata_i;
          presp_d[i] = s_hresp_i;
        end
      end else if (is_down[i]) begin
        m_hready_o[i] = s_hreadyout_i;
        m_hresp_o[i]  = s_hresp_i;
      end else if (is_gnt[i]) begin
        m_hready_o[i] = s_hreadyout_i;
      end else begin
        m_hready_o[i] = !req[i];
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      gnt_q   <= '0;
      rr_q    <= '0;
      dvld_q  <= 1'b0;
      down_q  <= '0;
      pend_q  <= '0;
      pdata_q <= '0;
      presp_q <= '0;
    end else begin
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      dvld_q  <= dvld_d;
      down_q  <= down_d;
      pend_q  <= pend_d;
      pdata_q <= pdata_d;
      presp_q <= presp_d;
    end
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: grant order, burst hold, buffered
// read data and buffered ERROR at a handover, and reset during a stalled burst.
module tb_ahb_master_arbiter;

  localparam int unsigned NM = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR   = 3'b001;
  localparam logic [2:0] INCR4  = 3'b011;

  logic                      hclk = 1'b0;
  logic                      hreset;
  logic [NM-1:0][AW-1:0]     m_haddr;
  logic [NM-1:0][DW-1:0]     m_hwdata;
  logic [NM-1:0][1:0]        m_htrans;
  logic [NM-1:0][2:0]        m_hsize;
  logic [NM-1:0][2:0]        m_hburst;
  logic [NM-1:0][3:0]        m_hprot;
  logic [NM-1:0]             m_hwrite;
  logic [NM-1:0]             m_hmastlock;
  logic [NM-1:0]             m_hready;
  logic [NM-1:0]             m_hresp;
  logic [NM-1:0][DW-1:0]     m_hrdata;
  logic [AW-1:0]             s_haddr;
  logic [1:0]                s_htrans;
  logic [2:0]                s_hsize;
  logic [2:0]                s_hburst;
  logic [3:0]                s_hprot;
  logic                      s_hwrite;
  logic                      s_hmastlock;
  logic                      s_hsel;
  logic [DW-1:0]             s_hwdata;
  logic                      s_hready;
  logic                      s_hreadyout;
  logic                      s_hresp;
  logic [DW-1:0]             s_hrdata;
  logic [1:0]                hmaster;

  int checks   = 0;
  int failures = 0;

  always #5 hclk = ~hclk;

  ahb_master_arbiter #(
    .NB_MASTERS    (NM),
    .AHB_DATA_WIDTH(DW),
    .AHB_ADDR_WIDTH(AW)
  ) dut (
    .hclk          (hclk),
    .hreset        (hreset),
    .m_haddr_i     (m_haddr),
    .m_hwdata_i    (m_hwdata),
    .m_htrans_i    (m_htrans),
    .m_hsize_i     (m_hsize),
    .m_hburst_i    (m_hburst),
    .m_hprot_i     (m_hprot),
    .m_hwrite_i    (m_hwrite),
    .m_hmastlock_i (m_hmastlock),
    .m_hready_o    (m_hready),
    .m_hresp_o     (m_hresp),
    .m_hrdata_o    (m_hrdata),
    .s_haddr_o     (s_haddr),
    .s_htrans_o    (s_htrans),
    .s_hsize_o     (s_hsize),
    .s_hburst_o    (s_hburst),
    .s_hprot_o     (s_hprot),
    .s_hwrite_o    (s_hwrite),
    .s_hmastlock_o (s_hmastlock),
    .s_hsel_o      (s_hsel),
    .s_hwdata_o    (s_hwdata),
    .s_hready_o    (s_hready),
    .s_hreadyout_i (s_hreadyout),
    .s_hresp_i     (s_hresp),
    .s_hrdata_i    (s_hrdata),
    .hmaster_o     (hmaster)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_m(input int i, input logic [1:0] tr, input logic [31:0] a, input logic [2:0] b);
    m_htrans[i] = tr;
    m_haddr[i]  = a;
    m_hburst[i] = b;
  endtask

  initial begin
    hreset      = 1'b1;
    m_haddr     = '0;
    m_hwdata    = '0;
    m_htrans    = '0;
    m_hsize     = {NM{3'b010}};
    m_hburst    = '0;
    m_hprot     = {NM{4'b0011}};
    m_hwrite    = '0;
    m_hmastlock = '0;
    s_hreadyout = 1'b1;
    s_hresp     = 1'b0;
    s_hrdata    = '0;
    tick();
    tick();

    // Reset state
    #1;
    chk("rst_hmaster", 64'(hmaster), 64'(0));
    chk("rst_hready", 64'(m_hready), 64'(4'b1111));
    chk("rst_hresp", 64'(m_hresp), 64'(0));
    chk("rst_htrans", 64'(s_htrans), 64'(IDLE));
    chk("rst_hsel", 64'(s_hsel), 64'(1));
    hreset = 1'b0;
    tick();

    // M1 and M2 request together: M1 first, M2 one cycle later
    set_m(1, NONSEQ, 32'h10, SINGLE);
    m_hwrite[1] = 1'b1;
    set_m(2, NONSEQ, 32'h20, SINGLE);
    #1;
    chk("t2_c0_hmaster", 64'(hmaster), 64'(0));
    chk("t2_c0_m1_hready", 64'(m_hready[1]), 64'(0));
    chk("t2_c0_m2_hready", 64'(m_hready[2]), 64'(0));
    tick();
    #1;
    chk("t2_c1_hmaster", 64'(hmaster), 64'(1));
    chk("t2_c1_haddr", 64'(s_haddr), 64'(32'h10));
    chk("t2_c1_hwrite", 64'(s_hwrite), 64'(1));
    chk("t2_c1_m1_hready", 64'(m_hready[1]), 64'(1));
    chk("t2_c1_m2_hready", 64'(m_hready[2]), 64'(0));
    tick();
    set_m(1, IDLE, 32'h0, SINGLE);
    m_hwrite[1] = 1'b0;
    m_hwdata[1] = 32'hAAAA5555;
    s_hrdata    = 32'h11;
    #1;
    chk("t2_c2_hmaster", 64'(hmaster), 64'(2));
    chk("t2_c2_haddr", 64'(s_haddr), 64'(32'h20));
    chk("t2_c2_m2_hready", 64'(m_hready[2]), 64'(1));
    chk("t2_c2_m1_hready", 64'(m_hready[1]), 64'(1));
    chk("t2_c2_hwdata", 64'(s_hwdata), 64'(32'hAAAA5555));
    chk("t2_c2_m1_hrdata", 64'(m_hrdata[1]), 64'(32'h11));
    tick();
    set_m(2, IDLE, 32'h0, SINGLE);
    #1;
    chk("t2_c3_m2_hready", 64'(m_hready[2]), 64'(1));
    tick();

    // M0 read loses the grant to M2 with its next address queued: read data buffered
    set_m(0, NONSEQ, 32'h20, SINGLE);
    #1;
    chk("t4_b0_m0_hready", 64'(m_hready[0]), 64'(0));
    tick();
    set_m(2, NONSEQ, 32'h40, SINGLE);
    #1;
    chk("t4_b1_hmaster", 64'(hmaster), 64'(0));
    chk("t4_b1_haddr", 64'(s_haddr), 64'(32'h20));
    chk("t4_b1_m0_hready", 64'(m_hready[0]), 64'(1));
    tick();
    set_m(0, NONSEQ, 32'h24, SINGLE);
    s_hrdata = 32'hCAFE0001;
    #1;
    chk("t4_b2_hmaster", 64'(hmaster), 64'(2));
    chk("t4_b2_haddr", 64'(s_haddr), 64'(32'h40));
    chk("t4_b2_m0_hready", 64'(m_hready[0]), 64'(0));
    chk("t4_b2_m2_hready", 64'(m_hready[2]), 64'(1));
    tick();
    set_m(2, IDLE, 32'h0, SINGLE);
    s_hrdata = 32'h22222222;
    #1;
    chk("t4_b3_hmaster", 64'(hmaster), 64'(0));
    chk("t4_b3_haddr", 64'(s_haddr), 64'(32'h24));
    chk("t4_b3_m0_hready", 64'(m_hready[0]), 64'(1));
    chk("t4_b3_m0_hrdata", 64'(m_hrdata[0]), 64'(32'hCAFE0001));
    chk("t4_b3_m2_hready", 64'(m_hready[2]), 64'(1));
    chk("t4_b3_m2_hrdata", 64'(m_hrdata[2]), 64'(32'h22222222));
    tick();
    set_m(0, IDLE, 32'h0, SINGLE);
    s_hrdata = 32'h33333333;
    #1;
    chk("t4_b4_m0_hready", 64'(m_hready[0]), 64'(1));
    chk("t4_b4_m0_hrdata", 64'(m_hrdata[0]), 64'(32'h33333333));
    tick();

    // Slave ERROR on a buffered M1 transfer while M3 holds the grant with an INCR burst
    s_hrdata = '0;
    set_m(1, NONSEQ, 32'h50, SINGLE);
    #1;
    chk("t5_c0_m1_hready", 64'(m_hready[1]), 64'(0));
    tick();
    set_m(3, NONSEQ, 32'h60, INCR);
    #1;
    chk("t5_c1_hmaster", 64'(hmaster), 64'(1));
    chk("t5_c1_haddr", 64'(s_haddr), 64'(32'h50));
    tick();
    set_m(1, NONSEQ, 32'h54, SINGLE);
    s_hreadyout = 1'b0;
    s_hresp     = 1'b1;
    #1;
    chk("t5_c2_hmaster", 64'(hmaster), 64'(3));
    chk("t5_c2_m1_hready", 64'(m_hready[1]), 64'(0));
    chk("t5_c2_m1_hresp", 64'(m_hresp[1]), 64'(0));
    chk("t5_c2_m3_hready", 64'(m_hready[3]), 64'(0));
    chk("t5_c2_s_hready", 64'(s_hready), 64'(0));
    tick();
    s_hreadyout = 1'b1;
    #1;
    chk("t5_c3_hmaster", 64'(hmaster), 64'(3));
    chk("t5_c3_m1_hready", 64'(m_hready[1]), 64'(0));
    tick();
    set_m(3, IDLE, 32'h0, SINGLE);
    s_hresp = 1'b0;
    #1;
    chk("t5_c4_hmaster", 64'(hmaster), 64'(3));
    chk("t5_c4_m1_hready", 64'(m_hready[1]), 64'(0));
    chk("t5_c4_m1_hresp", 64'(m_hresp[1]), 64'(1));
    tick();
    #1;
    chk("t5_c5_hmaster", 64'(hmaster), 64'(1));
    chk("t5_c5_haddr", 64'(s_haddr), 64'(32'h54));
    chk("t5_c5_m1_hready", 64'(m_hready[1]), 64'(1));
    chk("t5_c5_m1_hresp", 64'(m_hresp[1]), 64'(1));
    tick();
    set_m(1, IDLE, 32'h0, SINGLE);
    #1;
    chk("t5_c6_m1_hready", 64'(m_hready[1]), 64'(1));
    chk("t5_c6_m1_hresp", 64'(m_hresp[1]), 64'(0));
    tick();

    // M0 INCR4 keeps the grant against M3
    set_m(0, NONSEQ, 32'h100, INCR4);
    #1;
    chk("t3_d0_m0_hready", 64'(m_hready[0]), 64'(0));
    tick();
    set_m(3, NONSEQ, 32'h300, SINGLE);
    #1;
    chk("t3_beat0_hmaster", 64'(hmaster), 64'(0));
    chk("t3_beat0_haddr", 64'(s_haddr), 64'(32'h100));
    chk("t3_beat0_hburst", 64'(s_hburst), 64'(INCR4));
    chk("t3_beat0_m3_hready", 64'(m_hready[3]), 64'(0));
    tick();
    for (int b = 1; b < 4; b++) begin
      set_m(0, SEQ, 32'h100 + 32'(b * 4), INCR4);
      #1;
      chk("t3_beat_hmaster", 64'(hmaster), 64'(0));
      chk("t3_beat_haddr", 64'(s_haddr), 64'(32'h100 + 32'(b * 4)));
      chk("t3_beat_htrans", 64'(s_htrans), 64'(SEQ));
      chk("t3_beat_m3_hready", 64'(m_hready[3]), 64'(0));
      tick();
    end
    set_m(0, IDLE, 32'h0, SINGLE);
    #1;
    chk("t3_d5_hmaster", 64'(hmaster), 64'(0));
    chk("t3_d5_m3_hready", 64'(m_hready[3]), 64'(0));
    tick();
    #1;
    chk("t3_d6_hmaster", 64'(hmaster), 64'(3));
    chk("t3_d6_haddr", 64'(s_haddr), 64'(32'h300));
    chk("t3_d6_m3_hready", 64'(m_hready[3]), 64'(1));
    tick();
    set_m(3, IDLE, 32'h0, SINGLE);
    tick();

    // Reset in the middle of a wait-stated INCR4 from M2
    set_m(2, NONSEQ, 32'h200, INCR4);
    tick();
    #1;
    chk("t6_e1_hmaster", 64'(hmaster), 64'(2));
    tick();
    set_m(2, SEQ, 32'h204, INCR4);
    s_hreadyout = 1'b0;
    #1;
    chk("t6_e2_m2_hready", 64'(m_hready[2]), 64'(0));
    tick();
    hreset = 1'b1;
    tick();
    m_htrans    = '0;
    m_haddr     = '0;
    m_hburst    = '0;
    s_hreadyout = 1'b1;
    #1;
    chk("t6_rst_hmaster", 64'(hmaster), 64'(0));
    chk("t6_rst_hready", 64'(m_hready), 64'(4'b1111));
    chk("t6_rst_hresp", 64'(m_hresp), 64'(0));
    chk("t6_rst_htrans", 64'(s_htrans), 64'(IDLE));
    hreset = 1'b0;
    tick();
    #1;
    chk("t6_post_hmaster", 64'(hmaster), 64'(0));
    chk("t6_post_hready", 64'(m_hready), 64'(4'b1111));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
